// File: rtl/axi_lite_master_bridge_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_master_bridge_pkg
// Purpose : Shared AXI4-Lite types and constants for the core-to-AXI bridge.
//           Provides the protection and response types, the four AXI response
//           encodings and a helper that flags sub-word (misaligned) addresses.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package axi_lite_master_bridge_pkg;

    typedef logic [2:0] prot_t;
    typedef logic [1:0] resp_t;

    localparam resp_t OKAY   = 2'b00;
    localparam resp_t EXOKAY = 2'b01;
    localparam resp_t SLVERR = 2'b10;
    localparam resp_t DECERR = 2'b11;

    localparam prot_t PROT_DEFAULT = 3'b000;

    // An address is misaligned when any byte-offset bit inside one data word is set.
    // strb_width is a power of two, so (strb_width - 1) masks exactly those bits.
    function automatic logic is_misaligned(input logic [7:0] addr_lsbs,
                                           input int unsigned strb_width);
        logic [7:0] mask;
        mask = 8'(strb_width - 32'd1);
        return |(addr_lsbs & mask);
    endfunction

endpackage

// File: rtl/axi_lite_master_bridge_if.sv
// -----------------------------------------------------------------------------
// axi_lite_master_bridge_if
// Purpose : AXI4-Lite bus bundle (AW, W, B, AR, R channels).
// Modports: master - drives AW/W/AR payload+valid, bready, rready
//           slave  - drives awready, wready, B payload+valid, arready, R payload+valid
// Params  : ADDR_WIDTH, DATA_WIDTH (STRB_WIDTH = DATA_WIDTH/8)
// -----------------------------------------------------------------------------
interface axi_lite_master_bridge_if
    import axi_lite_master_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) ();

    logic [ADDR_WIDTH-1:0] awaddr;
    prot_t                 awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;

    resp_t                 bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ADDR_WIDTH-1:0] araddr;
    prot_t                 arprot;
    logic                  arvalid;
    logic                  arready;

    logic [DATA_WIDTH-1:0] rdata;
    resp_t                 rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_lite_master_bridge.sv
// -----------------------------------------------------------------------------
// axi_lite_master_bridge
// Purpose : Turns the core's single-request memory port into AXI4-Lite master
//           transactions, one in flight. Misaligned requests are answered
//           locally with SLVERR and never reach the bus.
// Ports   : aclk, areset        clock, synchronous active-high reset
//           req_valid/req_ready request handshake (ready only in IDLE)
//           req_write, req_addr, req_wdata, req_wstrb  request payload
//           rsp_valid/rsp_ready response handshake
//           rsp_rdata, rsp_resp response payload
//           m                   AXI4-Lite master port (all five channels)
// Params  : ADDR_WIDTH, DATA_WIDTH, PROT (constant awprot/arprot)
// -----------------------------------------------------------------------------
module axi_lite_master_bridge
    import axi_lite_master_bridge_pkg::*;
#(
    parameter int    ADDR_WIDTH = 32,
    parameter int    DATA_WIDTH = 32,
    parameter prot_t PROT       = 3'b000,
    localparam int   STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [STRB_WIDTH-1:0]   req_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output resp_t                   rsp_resp,
    axi_lite_master_bridge_if.master m
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t                r_state;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    resp_t                 r_rsp_resp;

    // A channel counts as done if it finished earlier or handshakes right now.
    logic w_aw_done;
    logic w_w_done;

    // Completion tracking for the independent AW and W channels.
    always_comb begin
        w_aw_done = (~r_awvalid) | m.awready;
        w_w_done  = (~r_wvalid)  | m.wready;
    end

    // Transaction FSM together with all bus-facing and response registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state     <= S_IDLE;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= {ADDR_WIDTH{1'b0}};
            r_araddr    <= {ADDR_WIDTH{1'b0}};
            r_wdata     <= {DATA_WIDTH{1'b0}};
            r_wstrb     <= {STRB_WIDTH{1'b0}};
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DATA_WIDTH{1'b0}};
            r_rsp_resp  <= OKAY;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (is_misaligned(req_addr[7:0], STRB_WIDTH)) begin
                            // Local reject: answer straight away, bus stays quiet.
                            r_rsp_valid <= 1'b1;
                            r_rsp_resp  <= SLVERR;
                            r_rsp_rdata <= {DATA_WIDTH{1'b0}};
                            r_state     <= S_RESP;
                        end else if (req_write) begin
                            r_awaddr  <= req_addr;
                            r_wdata   <= req_wdata;
                            r_wstrb   <= req_wstrb;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WRITE;
                        end else begin
                            r_araddr  <= req_addr;
                            r_arvalid <= 1'b1;
                            r_state   <= S_RADDR;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_aw_done && w_w_done) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= S_WRESP;
                    end else begin
                        // Each valid drops on its own handshake; payload stays put.
                        if (r_awvalid && m.awready) begin
                            r_awvalid <= 1'b0;
                        end
                        if (r_wvalid && m.wready) begin
                            r_wvalid <= 1'b0;
                        end
                    end
                end
                S_WRESP: begin
                    if (m.bvalid) begin
                        r_bready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_resp  <= m.bresp;
                        r_rsp_rdata <= {DATA_WIDTH{1'b0}};
                        r_state     <= S_RESP;
                    end
                end
                S_RADDR: begin
                    if (m.arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (m.rvalid) begin
                        // Read data is kept even when the slave signals an error.
                        r_rready    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= m.rdata;
                        r_rsp_resp  <= m.rresp;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Output mapping; req_ready is held low while reset is asserted.
    always_comb begin
        req_ready = (r_state == S_IDLE) & ~areset;
        rsp_valid = r_rsp_valid;
        rsp_rdata = r_rsp_rdata;
        rsp_resp  = r_rsp_resp;
        m.awaddr  = r_awaddr;
        m.awprot  = PROT;
        m.awvalid = r_awvalid;
        m.wdata   = r_wdata;
        m.wstrb   = r_wstrb;
        m.wvalid  = r_wvalid;
        m.bready  = r_bready;
        m.araddr  = r_araddr;
        m.arprot  = PROT;
        m.arvalid = r_arvalid;
        m.rready  = r_rready;
    end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master_bridge
// Directed and randomized checks of the AXI4-Lite master bridge against a
// latency/response model and a byte-lane memory model kept in the bench.
// -----------------------------------------------------------------------------
module tb_axi_lite_master_bridge;
    import axi_lite_master_bridge_pkg::*;

    logic        aclk;
    logic        areset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    resp_t       rsp_resp;

    int checks = 0;
    int errors = 0;

    axi_lite_master_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

    axi_lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT(3'b000)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .m         (m_if)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- slave responder with programmable wait states ----------
    int    aw_wait, w_wait, b_wait, ar_wait, r_wait;
    resp_t cfg_bresp, cfg_rresp;
    int    aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    int    aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic  aw_done, w_done, b_pend, r_pend;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    logic [31:0] mem [0:255];
    logic        aw_now, w_now;
    logic [31:0] eff_awaddr, eff_wdata;
    logic [3:0]  eff_wstrb;

    assign m_if.awready = m_if.awvalid && !aw_done && (aw_cnt >= aw_wait);
    assign m_if.wready  = m_if.wvalid  && !w_done  && (w_cnt  >= w_wait);
    assign m_if.bvalid  = b_pend && (b_cnt >= b_wait);
    assign m_if.bresp   = m_if.bvalid ? cfg_bresp : OKAY;
    assign m_if.arready = m_if.arvalid && !r_pend && (ar_cnt >= ar_wait);
    assign m_if.rvalid  = r_pend && (r_cnt >= r_wait);
    assign m_if.rdata   = m_if.rvalid ? mem[s_araddr[9:2]] : 32'h0;
    assign m_if.rresp   = m_if.rvalid ? cfg_rresp : OKAY;
    assign aw_now       = m_if.awvalid && m_if.awready;
    assign w_now        = m_if.wvalid && m_if.wready;
    assign eff_awaddr   = aw_now ? m_if.awaddr : s_awaddr;
    assign eff_wdata    = w_now  ? m_if.wdata  : s_wdata;
    assign eff_wstrb    = w_now  ? m_if.wstrb  : s_wstrb;

    // Slave state: wait counters, handshake tallies and strobed memory writes.
    always @(posedge aclk) begin
        if (areset) begin
            aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
            aw_done <= 1'b0; w_done <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            s_awaddr <= 32'h0; s_wdata <= 32'h0; s_wstrb <= 4'h0; s_araddr <= 32'h0;
        end else begin
            if (aw_now) begin
                aw_done <= 1'b1; s_awaddr <= m_if.awaddr; aw_cnt <= 0; aw_hs <= aw_hs + 1;
            end else if (m_if.awvalid) begin
                aw_cnt <= aw_cnt + 1;
            end
            if (w_now) begin
                w_done <= 1'b1; s_wdata <= m_if.wdata; s_wstrb <= m_if.wstrb; w_cnt <= 0; w_hs <= w_hs + 1;
            end else if (m_if.wvalid) begin
                w_cnt <= w_cnt + 1;
            end
            if (!b_pend && (aw_done || aw_now) && (w_done || w_now)) begin
                b_pend <= 1'b1;
                b_cnt  <= 0;
                for (int i = 0; i < 4; i++) begin
                    if (eff_wstrb[i]) mem[eff_awaddr[9:2]][8*i +: 8] <= eff_wdata[8*i +: 8];
                end
            end else if (b_pend) begin
                if (m_if.bvalid && m_if.bready) begin
                    b_pend <= 1'b0; aw_done <= 1'b0; w_done <= 1'b0; b_hs <= b_hs + 1;
                end else begin
                    b_cnt <= b_cnt + 1;
                end
            end
            if (m_if.arvalid && m_if.arready) begin
                r_pend <= 1'b1; r_cnt <= 0; s_araddr <= m_if.araddr; ar_cnt <= 0; ar_hs <= ar_hs + 1;
            end else if (m_if.arvalid) begin
                ar_cnt <= ar_cnt + 1;
            end
            if (r_pend) begin
                if (m_if.rvalid && m_if.rready) begin
                    r_pend <= 1'b0; r_hs <= r_hs + 1;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    // ---------------- reference model -----------------------------------------
    logic [31:0] ref_mem [0:255];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One complete request/response. Called and returns at a falling edge.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int aww, input int ww, input int bw,
                           input int arw, input int rw, input resp_t bresp_c,
                           input resp_t rresp_c, input int hold);
        bit          mis;
        int          lat, mx;
        resp_t       exp_resp;
        logic [31:0] exp_rdata;
        int          aw0, w0, b0, ar0, r0;
        aw_wait = aww; w_wait = ww; b_wait = bw; ar_wait = arw; r_wait = rw;
        cfg_bresp = bresp_c; cfg_rresp = rresp_c;
        mis = (addr % 4) != 0;
        mx  = (aww > ww) ? aww : ww;
        if (mis)     lat = 1;
        else if (wr) lat = 3 + mx + bw;
        else         lat = 3 + arw + rw;
        exp_resp  = mis ? SLVERR : (wr ? bresp_c : rresp_c);
        exp_rdata = (mis || wr) ? 32'h0 : ref_mem[addr[9:2]];
        if (!mis && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) ref_mem[addr[9:2]][8*i +: 8] = wdata[8*i +: 8];
            end
        end
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;

        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        @(posedge aclk);
        @(negedge aclk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) @(negedge aclk);
            chk("awvalid", m_if.awvalid, wr && !mis && c <= 1 + aww);
            chk("wvalid",  m_if.wvalid,  wr && !mis && c <= 1 + ww);
            chk("bready",  m_if.bready,  wr && !mis && c >= 2 + mx && c <= 2 + mx + bw);
            chk("arvalid", m_if.arvalid, !wr && !mis && c <= 1 + arw);
            chk("rready",  m_if.rready,  !wr && !mis && c >= 2 + arw && c <= 2 + arw + rw);
            chk("rsp_valid_timing", rsp_valid, c == lat);
            chk("req_ready_busy", req_ready, 0);
            if (m_if.awvalid) begin
                chk("awaddr", m_if.awaddr, addr);
                chk("awprot", m_if.awprot, 0);
            end
            if (m_if.wvalid) begin
                chk("wdata", m_if.wdata, wdata);
                chk("wstrb", m_if.wstrb, strb);
            end
            if (m_if.arvalid) begin
                chk("araddr", m_if.araddr, addr);
                chk("arprot", m_if.arprot, 0);
            end
        end
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_resp",  rsp_resp,  exp_resp);
        for (int h = 0; h < hold; h++) begin
            @(negedge aclk);
            chk("hold_rsp_valid", rsp_valid, 1);
            chk("hold_rsp_rdata", rsp_rdata, exp_rdata);
            chk("hold_rsp_resp",  rsp_resp,  exp_resp);
            chk("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("aw_hs_count", aw_hs - aw0, (wr && !mis) ? 1 : 0);
        chk("w_hs_count",  w_hs - w0,   (wr && !mis) ? 1 : 0);
        chk("b_hs_count",  b_hs - b0,   (wr && !mis) ? 1 : 0);
        chk("ar_hs_count", ar_hs - ar0, (!wr && !mis) ? 1 : 0);
        chk("r_hs_count",  r_hs - r0,   (!wr && !mis) ? 1 : 0);
    endtask

    // ---------------- directed + randomized sequence --------------------------
    initial begin
        logic [31:0] a, d;
        bit          wr;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        cfg_bresp = OKAY; cfg_rresp = OKAY;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        areset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_wstrb = 4'h0; rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_resp",  rsp_resp,  OKAY);
        chk("rst_valids", {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready}, 0);
        chk("rst_awaddr", m_if.awaddr, 0);
        chk("rst_araddr", m_if.araddr, 0);
        chk("rst_wdata",  m_if.wdata,  0);
        chk("rst_wstrb",  m_if.wstrb,  0);
        areset = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("rst_release_req_ready", req_ready, 1);

        // 1: aligned write, zero-wait slave
        run_txn(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, OKAY, OKAY, 0);
        // 2: awready at cycle 1, wready at cycle 4
        run_txn(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 0, 3, 0, 0, 0, OKAY, OKAY, 0);
        // 3: read after five wait cycles with SLVERR, data still returned
        run_txn(1'b1, 32'h0000_2004, 32'h1234_5678, 4'hF, 0, 0, 0, 0, 0, OKAY, OKAY, 0);
        run_txn(1'b0, 32'h0000_2004, 32'h0, 4'h0, 0, 0, 0, 0, 5, OKAY, SLVERR, 0);
        // 4: misaligned read is rejected locally
        run_txn(1'b0, 32'h0000_2006, 32'h0, 4'h0, 0, 0, 0, 0, 0, OKAY, OKAY, 0);
        // 5: response held for ten cycles, then immediate back-to-back request
        run_txn(1'b0, 32'h0000_2004, 32'h0, 4'h0, 1, 0, 0, 1, 1, OKAY, EXOKAY, 10);
        run_txn(1'b1, 32'h0000_2008, 32'hA5A5_0F0F, 4'h5, 1, 2, 1, 0, 0, DECERR, OKAY, 0);

        // 6: reset while waiting in WRESP with bvalid low
        aw_wait = 0; w_wait = 0; b_wait = 40;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_1000;
        req_wdata = 32'h0BAD_F00D; req_wstrb = 4'hF;
        @(posedge aclk);
        @(negedge aclk);
        req_valid = 1'b0;
        @(negedge aclk);
        chk("wresp_bready", m_if.bready, 1);
        chk("wresp_bvalid", m_if.bvalid, 0);
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        chk("midrst_valids", {m_if.awvalid, m_if.wvalid, m_if.bready, m_if.arvalid, m_if.rready}, 0);
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_req_ready", req_ready, 0);
        areset = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        chk("after_rst_req_ready", req_ready, 1);
        chk("after_rst_rsp_valid", rsp_valid, 0);

        // Randomized: seed a small region with full-word writes, then mix traffic
        for (int i = 0; i < 8; i++) begin
            run_txn(1'b1, 32'h0000_3100 + 32'(i * 4), $urandom, 4'hF, 0, 0, 0, 0, 0, OKAY, OKAY, 0);
        end
        for (int n = 0; n < 30; n++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 32'h0000_3100 + 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(1, 3));
            d  = $urandom;
            run_txn(wr, a, d, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    resp_t'($urandom_range(0, 3)), resp_t'($urandom_range(0, 3)),
                    $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
